// File: rtl/xgriscv_sc.sv
// xgriscv_sc: single-cycle RV32I core with word-addressed instruction and data memories.
// Every instruction is fetched, executed and retired in one clock; pcW is the PC register.

// Instruction memory: combinational read, word index wraps modulo the depth.
module xgriscv_imem #(
    parameter int unsigned WORDS = 256
) (
    input  logic [29:0] addr,
    output logic [31:0] rd
);
    localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0]   RAM [0:WORDS-1];
    logic [AW-1:0] idx;

    assign idx = AW'(addr % 30'(WORDS));
    assign rd  = RAM[idx];
endmodule

module xgriscv_sc #(
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned DMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h00000000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [31:0] pcW
);
    localparam int unsigned DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] instr;

    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    logic [31:0] rf [0:31];
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic        rf_we;
    logic [31:0] rf_wd;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_alt;
    logic [31:0] alu_y;
    logic        br_taken;
    logic        opimm_ok;
    logic        op_ok;

    logic [31:0]    dmem [0:DMEM_WORDS-1];
    logic [31:0]    mem_addr;
    logic [DAW-1:0] dm_idx;
    logic [31:0]    dm_rdata;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [31:0]    ld_data;
    logic           ld_ok;
    logic [3:0]     st_be;
    logic [31:0]    st_data;
    logic           dm_we;

    assign pcW      = pc;
    assign pc_plus4 = pc + 32'd4;

    xgriscv_imem #(.WORDS(IMEM_WORDS)) U_imem (
        .addr (pc[31:2]),
        .rd   (instr)
    );

    assign op  = instr[6:0];
    assign rd  = instr[11:7];
    assign f3  = instr[14:12];
    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign f7  = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rs1v = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign rs2v = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

    // ALU operand selection; bit 30 selects SUB/SRA, but only SRAI among immediates
    assign alu_a   = rs1v;
    assign alu_b   = (op == OP_OP) ? rs2v : imm_i;
    assign alu_alt = (op == OP_OP) ? instr[30] : ((f3 == 3'b101) && instr[30]);

    // Legal funct7 encodings for register-immediate and register-register ops
    assign opimm_ok = (f3 == 3'b001) ? (f7 == 7'b0000000) :
                      (f3 == 3'b101) ? ((f7 == 7'b0000000) || (f7 == 7'b0100000)) : 1'b1;
    assign op_ok    = (f7 == 7'b0000000) ||
                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));

    // ALU: arithmetic, logic, shifts and set-less-than selected by funct3
    always_comb begin
        alu_y = '0;
        case (f3)
            3'b000: alu_y = alu_alt ? (alu_a - alu_b) : (alu_a + alu_b);
            3'b001: alu_y = alu_a << alu_b[4:0];
            3'b010: alu_y = {31'b0, ($signed(alu_a) < $signed(alu_b))};
            3'b011: alu_y = {31'b0, (alu_a < alu_b)};
            3'b100: alu_y = alu_a ^ alu_b;
            3'b101: alu_y = alu_alt ? 32'($signed(alu_a) >>> alu_b[4:0]) : (alu_a >> alu_b[4:0]);
            3'b110: alu_y = alu_a | alu_b;
            3'b111: alu_y = alu_a & alu_b;
            default: alu_y = '0;
        endcase
    end

    // Branch condition; reserved funct3 codes never branch
    always_comb begin
        br_taken = 1'b0;
        case (f3)
            3'b000: br_taken = (rs1v == rs2v);
            3'b001: br_taken = (rs1v != rs2v);
            3'b100: br_taken = ($signed(rs1v) < $signed(rs2v));
            3'b101: br_taken = !($signed(rs1v) < $signed(rs2v));
            3'b110: br_taken = (rs1v < rs2v);
            3'b111: br_taken = !(rs1v < rs2v);
            default: br_taken = 1'b0;
        endcase
    end

    assign mem_addr = rs1v + ((op == OP_STORE) ? imm_s : imm_i);
    assign dm_idx   = DAW'(mem_addr[31:2] % 30'(DMEM_WORDS));
    assign dm_rdata = dmem[dm_idx];
    assign ld_byte  = dm_rdata[{mem_addr[1:0], 3'b000} +: 8];
    assign ld_half  = mem_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    // Load lane extraction with sign or zero extension
    always_comb begin
        ld_data = '0;
        ld_ok   = 1'b1;
        case (f3)
            3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001: ld_data = {{16{ld_half[15]}}, ld_half};
            3'b010: ld_data = dm_rdata;
            3'b100: ld_data = {24'b0, ld_byte};
            3'b101: ld_data = {16'b0, ld_half};
            default: ld_ok  = 1'b0;
        endcase
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        st_be   = '0;
        st_data = '0;
        case (f3)
            3'b000: begin
                st_be   = 4'(4'b0001 << mem_addr[1:0]);
                st_data = {4{rs2v[7:0]}};
            end
            3'b001: begin
                st_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{rs2v[15:0]}};
            end
            3'b010: begin
                st_be   = 4'b1111;
                st_data = rs2v;
            end
            default: begin
                st_be   = '0;
                st_data = '0;
            end
        endcase
    end

    // Main decode: next PC, writeback and store enable; unknown opcodes act as NOP
    always_comb begin
        pc_next = pc_plus4;
        rf_we   = 1'b0;
        rf_wd   = '0;
        dm_we   = 1'b0;
        case (op)
            OP_LUI: begin
                rf_we = 1'b1;
                rf_wd = imm_u;
            end
            OP_AUIPC: begin
                rf_we = 1'b1;
                rf_wd = pc + imm_u;
            end
            OP_JAL: begin
                rf_we   = 1'b1;
                rf_wd   = pc_plus4;
                pc_next = pc + imm_j;
            end
            OP_JALR: begin
                if (f3 == 3'b000) begin
                    rf_we   = 1'b1;
                    rf_wd   = pc_plus4;
                    pc_next = (rs1v + imm_i) & ~32'd1;
                end
            end
            OP_BRANCH: begin
                if (br_taken) pc_next = pc + imm_b;
            end
            OP_LOAD: begin
                rf_we = ld_ok;
                rf_wd = ld_data;
            end
            OP_STORE: begin
                dm_we = (st_be != 4'b0000);
            end
            OP_OPIMM: begin
                rf_we = opimm_ok;
                rf_wd = alu_y;
            end
            OP_OP: begin
                rf_we = op_ok;
                rf_wd = alu_y;
            end
            default: begin
                pc_next = pc_plus4;
            end
        endcase
    end

    // PC register
    always_ff @(posedge clk) begin
        if (rstn) pc <= RESET_PC;
        else      pc <= pc_next;
    end

    // Register file write port; x0 storage is held at zero
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (rf_we && (rd != 5'd0)) begin
            rf[rd] <= rf_wd;
        end
    end

    // Data memory byte-lane write; contents survive reset
    always_ff @(posedge clk) begin
        if (!rstn && dm_we) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) dmem[dm_idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_xgriscv_sc.sv
// Directed bench for xgriscv_sc: NOP stream, loads/stores, ALU, branches, jumps, mid-run reset.
module tb_xgriscv_sc;
    logic        clk;
    logic        rstn;
    logic [31:0] pcW;

    int vectors;
    int miscompares;

    xgriscv_sc dut (
        .clk  (clk),
        .rstn (rstn),
        .pcW  (pcW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction

    task automatic fill_nops();
        for (int k = 0; k < 256; k++) dut.U_imem.RAM[k] = 32'h00000013;
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b1;
        for (int k = 0; k < 256; k++) dut.dmem[k] = 32'h0;

        // NOP stream from reset
        fill_nops();
        do_reset();
        check("reset_pc", pcW, 32'h0);
        check("reset_x5", dut.rf[5], 32'h0);
        tick(); check("nop_pc4", pcW, 32'h4);
        tick(); check("nop_pc8", pcW, 32'h8);
        tick(); check("nop_pcc", pcW, 32'hC);

        // Loads, stores, compares, illegal opcode, AUIPC, JALR to zero
        fill_nops();
        dut.U_imem.RAM[0]  = 32'h00100293;           // addi x5,x0,1
        dut.U_imem.RAM[1]  = 32'hFFFFF3B7;           // lui  x7,0xFFFFF
        dut.U_imem.RAM[2]  = enc_s(0, 7, 0, 2);      // sw   x7,0(x0)
        dut.U_imem.RAM[3]  = enc_i(0, 0, 2, 8, 3);   // lw   x8,0(x0)
        dut.U_imem.RAM[4]  = enc_i(3, 0, 0, 9, 3);   // lb   x9,3(x0)
        dut.U_imem.RAM[5]  = enc_i(1, 0, 4, 10, 3);  // lbu  x10,1(x0)
        dut.U_imem.RAM[6]  = enc_s(2, 5, 0, 0);      // sb   x5,2(x0)
        dut.U_imem.RAM[7]  = enc_i(0, 0, 2, 17, 3);  // lw   x17,0(x0)
        dut.U_imem.RAM[8]  = enc_i(2, 0, 1, 18, 3);  // lh   x18,2(x0)
        dut.U_imem.RAM[9]  = enc_i(0, 0, 5, 19, 3);  // lhu  x19,0(x0)
        dut.U_imem.RAM[10] = enc_s(6, 5, 0, 1);      // sh   x5,6(x0)
        dut.U_imem.RAM[11] = enc_i(4, 0, 2, 20, 3);  // lw   x20,4(x0)
        dut.U_imem.RAM[12] = enc_i(3, 0, 2, 21, 3);  // lw   x21,3(x0) misaligned
        dut.U_imem.RAM[13] = enc_r(0, 7, 5, 0, 22);  // add  x22,x5,x7
        dut.U_imem.RAM[14] = enc_r(0, 5, 7, 2, 23);  // slt  x23,x7,x5
        dut.U_imem.RAM[15] = enc_r(0, 5, 7, 3, 24);  // sltu x24,x7,x5
        dut.U_imem.RAM[16] = 32'h00000073;           // ecall -> NOP
        dut.U_imem.RAM[17] = 32'h00001C97;           // auipc x25,1
        dut.U_imem.RAM[18] = 32'h00000067;           // jalr x0,0(x0)
        do_reset();
        check("ls_reset_pc", pcW, 32'h0);
        for (int k = 0; k < 16; k++) tick();
        check("ls_pc40", pcW, 32'h40);
        check("ls_x5", dut.rf[5], 32'h00000001);
        check("ls_x7", dut.rf[7], 32'hFFFFF000);
        check("lw_x8", dut.rf[8], 32'hFFFFF000);
        check("lb_x9", dut.rf[9], 32'hFFFFFFFF);
        check("lbu_x10", dut.rf[10], 32'h000000F0);
        check("sb_lw_x17", dut.rf[17], 32'hFF01F000);
        check("lh_x18", dut.rf[18], 32'hFFFFFF01);
        check("lhu_x19", dut.rf[19], 32'h0000F000);
        check("sh_lw_x20", dut.rf[20], 32'h00010000);
        check("lw_mis_x21", dut.rf[21], 32'hFF01F000);
        check("add_x22", dut.rf[22], 32'hFFFFF001);
        check("slt_x23", dut.rf[23], 32'h00000001);
        check("sltu_x24", dut.rf[24], 32'h00000000);
        check("dmem0", dut.dmem[0], 32'hFF01F000);
        check("dmem1", dut.dmem[1], 32'h00010000);
        tick(); check("ecall_pc", pcW, 32'h44);
        check("ecall_x5", dut.rf[5], 32'h00000001);
        tick(); check("auipc_pc", pcW, 32'h48);
        check("auipc_x25", dut.rf[25], 32'h00001044);
        tick(); check("jalr0_pc", pcW, 32'h0);

        // ALU, branches and jumps
        fill_nops();
        dut.U_imem.RAM[0]  = 32'h00100293;             // addi x5,x0,1
        dut.U_imem.RAM[1]  = 32'hFFFFF3B7;             // lui  x7,0xFFFFF
        dut.U_imem.RAM[2]  = 32'h00500013;             // addi x0,x0,5
        dut.U_imem.RAM[3]  = enc_i(4, 0, 0, 14, 'h13); // addi x14,x0,4
        dut.U_imem.RAM[4]  = 32'h00000463;             // beq  x0,x0,+8
        dut.U_imem.RAM[5]  = enc_i(99, 0, 0, 5, 'h13); // skipped
        dut.U_imem.RAM[6]  = enc_r('h20, 14, 7, 5, 13);// sra  x13,x7,x14
        dut.U_imem.RAM[7]  = enc_r('h20, 7, 5, 0, 12); // sub  x12,x5,x7
        dut.U_imem.RAM[8]  = enc_j(16, 1);             // jal  x1,+16
        dut.U_imem.RAM[9]  = enc_i(77, 0, 0, 5, 'h13); // skipped
        dut.U_imem.RAM[10] = enc_i(77, 0, 0, 5, 'h13); // skipped
        dut.U_imem.RAM[11] = enc_i(77, 0, 0, 5, 'h13); // skipped
        dut.U_imem.RAM[12] = enc_b(8, 6, 7, 4);        // blt  x7,x6,+8
        dut.U_imem.RAM[13] = enc_i(55, 0, 0, 5, 'h13); // skipped
        dut.U_imem.RAM[14] = enc_b(8, 6, 7, 6);        // bltu x7,x6,+8
        dut.U_imem.RAM[15] = enc_i('h41, 0, 0, 15, 'h13); // addi x15,x0,0x41
        dut.U_imem.RAM[16] = enc_i(0, 15, 0, 16, 'h67);   // jalr x16,0(x15)
        do_reset();
        check("alu_reset_pc", pcW, 32'h0);
        tick(); tick(); tick(); tick();
        check("pre_beq_pc", pcW, 32'h10);
        tick(); check("beq_pc", pcW, 32'h18);
        tick(); tick(); check("pre_jal_pc", pcW, 32'h20);
        tick(); check("jal_pc", pcW, 32'h30);
        check("jal_x1", dut.rf[1], 32'h00000024);
        tick(); check("blt_pc", pcW, 32'h38);
        tick(); check("bltu_pc", pcW, 32'h3C);
        tick(); tick(); check("jalr_odd_pc", pcW, 32'h40);
        check("jalr_x16", dut.rf[16], 32'h00000044);
        check("alu_x5", dut.rf[5], 32'h00000001);
        check("alu_x7", dut.rf[7], 32'hFFFFF000);
        check("alu_x0", dut.rf[0], 32'h00000000);
        check("sra_x13", dut.rf[13], 32'hFFFFFF00);
        check("sub_x12", dut.rf[12], 32'h00001001);
        tick(); check("jalr_loop_pc", pcW, 32'h40);

        // Mid-run reset: PC and registers clear, data memory retained
        do_reset();
        check("mid_reset_pc", pcW, 32'h0);
        check("mid_reset_x5", dut.rf[5], 32'h0);
        check("mid_reset_x7", dut.rf[7], 32'h0);
        check("mid_reset_dmem0", dut.dmem[0], 32'hFF01F000);
        check("mid_reset_dmem1", dut.dmem[1], 32'h00010000);
        tick(); check("post_reset_pc", pcW, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
